// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the MIPS boot loader
package mips_pkg;

  localparam int ADDR_W_DEF     = 7;
  localparam int DATA_W_DEF     = 32;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DATA  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } loader_state_t;

endpackage

// File: rtl/loader_word_packer.sv
// rtl/loader_word_packer.sv - packs big-endian bytes into words, pulses word_ready on the last byte
module loader_word_packer
  import mips_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              word_ready,
  output logic [DATA_W-1:0] word
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  // Only the first three bytes need storage; the fourth is taken straight from in_data.
  logic [DATA_W-9:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign word       = {shift_q, in_data};
  assign word_ready = in_valid && !clear && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (in_valid) begin
      shift_d = word[DATA_W-9:0];
      cnt_d   = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - loads a checksummed byte frame into RAM and releases the CPU reset
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reload,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  // One extra bit so a full 2**ADDR_W-word frame is countable without wrapping.
  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  last_q, last_d;
  logic [7:0]        acc_q, acc_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic              pk_clear;
  logic              pk_valid;
  logic              pk_ready;
  logic [DATA_W-1:0] pk_word;

  loader_word_packer #(.DATA_W(DATA_W)) u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (pk_clear),
    .in_valid   (pk_valid),
    .in_data    (rx_data),
    .word_ready (pk_ready),
    .word       (pk_word)
  );

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    last_d   = last_q;
    acc_d    = acc_q;
    mem_we_d = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    pk_clear = 1'b0;
    pk_valid = 1'b0;

    if (reload) begin
      // Dropping the packer contents also kills any write that would issue next cycle.
      state_d  = IDLE;
      pk_clear = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          pk_clear = 1'b1;
          if (rx_valid) begin
            last_d  = (rx_data == 8'd0) ? CNT_W'((1 << ADDR_W) - 1)
                                        : CNT_W'(rx_data) - CNT_W'(1);
            wcnt_d  = '0;
            acc_d   = 8'd0;
            state_d = DATA;
          end
        end
        DATA: begin
          pk_valid = rx_valid;
          if (rx_valid) begin
            acc_d = acc_q ^ rx_data;
          end
          if (pk_ready) begin
            mem_we_d = 1'b1;
            addr_d   = wcnt_q[ADDR_W-1:0];
            wdata_d  = pk_word;
            wcnt_d   = wcnt_q + 1'b1;
            if (wcnt_q == last_q) begin
              state_d = CHECK;
            end
          end
        end
        CHECK: begin
          if (rx_valid) begin
            state_d = (rx_data == acc_q) ? DONE : ERROR;
          end
        end
        DONE:    state_d = DONE;
        ERROR:   state_d = ERROR;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      last_q   <= '0;
      acc_q    <= 8'd0;
      mem_we_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      last_q   <= last_d;
      acc_q    <= acc_d;
      mem_we_q <= mem_we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == DATA) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERROR);
  assign cpu_rst   = (state_q != DONE);

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - randomized frame-level model check of mips_prog_loader
module tb_mips_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reload = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst, busy, done, err;

  mips_prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .reload    (reload),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Frame-level model: tracks bytes seen in the current frame, not the FSM.
  bit          m_active, m_done, m_err;
  int          m_n, m_bytes;
  logic [7:0]  m_acc;
  logic [31:0] m_word;
  logic        e_we;
  logic [6:0]  e_addr;
  logic [31:0] e_wdata;

  logic [6:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  task automatic model_update();
    e_we = 1'b0;
    if (rst) begin
      m_active = 0; m_done = 0; m_err = 0;
      e_addr = 7'd0; e_wdata = 32'd0;
    end else if (reload) begin
      m_active = 0; m_done = 0; m_err = 0;
    end else if (rx_valid) begin
      if (!m_active && !m_done && !m_err) begin
        m_active = 1;
        m_n = (rx_data == 8'd0) ? 128 : int'(rx_data);
        m_bytes = 0;
        m_acc = 8'd0;
      end else if (m_active && m_bytes < 4 * m_n) begin
        m_word = {m_word[23:0], rx_data};
        m_acc = m_acc ^ rx_data;
        m_bytes++;
        if (m_bytes % 4 == 0) begin
          e_we = 1'b1;
          e_addr = 7'(m_bytes / 4 - 1);
          e_wdata = m_word;
        end
      end else if (m_active) begin
        m_active = 0;
        if (rx_data == m_acc) m_done = 1;
        else m_err = 1;
      end
    end
  endtask

  task automatic compare();
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wdata", mem_wdata, e_wdata);
    check("busy", 32'(busy), 32'(m_active));
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    check("cpu_rst", 32'(cpu_rst), 32'(!m_done));
    if (mem_we === 1'b1) begin
      check("cpu_rst_during_we", 32'(cpu_rst), 32'd1);
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  endtask

  task automatic tick(input logic v, input logic [7:0] d, input logic rl, input logic r);
    @(negedge clk);
    rx_valid = v; rx_data = d; reload = rl; rst = r;
    @(posedge clk);
    model_update();
    #1;
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'($urandom), 1'b0, 1'b0);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    tick(1'b1, b, 1'b0, 1'b0);
    idle(gap);
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [31:0] words[], input bit good, input int gap);
    logic [7:0] x;
    x = 8'd0;
    send(hdr, gap);
    foreach (words[i]) begin
      for (int k = 3; k >= 0; k--) begin
        send(words[i][k*8 +: 8], gap);
        x = x ^ words[i][k*8 +: 8];
      end
    end
    send(good ? x : ~x, gap);
  endtask

  function automatic logic [31:0] log_d(input int i);
    if (i < wr_data.size()) return wr_data[i];
    return 'x;
  endfunction

  function automatic logic [31:0] log_a(input int i);
    if (i < wr_addr.size()) return 32'(wr_addr[i]);
    return 'x;
  endfunction

  logic [31:0] w2[];
  logic [31:0] w1[];
  logic [31:0] wfib[];
  logic [31:0] wbig[];
  logic [31:0] wr[];
  int base;

  initial begin
    m_active = 0; m_done = 0; m_err = 0; m_n = 0; m_bytes = 0;
    m_acc = 8'd0; m_word = 32'd0; e_we = 0; e_addr = 0; e_wdata = 0;

    repeat (3) tick(1'b0, 8'd0, 1'b0, 1'b1);
    check("reset_cpu_rst", 32'(cpu_rst), 32'd1);
    check("reset_mem_addr", 32'(mem_addr), 32'd0);

    // Good 2-word frame, one byte every 4 cycles
    w2 = new[2];
    w2[0] = 32'h20190040; w2[1] = 32'h00008020;
    base = wr_data.size();
    send(8'h02, 3);
    foreach (w2[i]) for (int k = 3; k >= 0; k--) send(w2[i][k*8 +: 8], 3);
    tick(1'b1, 8'hD9, 1'b0, 1'b0);
    check("t1_done_after_d9", 32'(done), 32'd1);
    check("t1_cpu_rst_after_d9", 32'(cpu_rst), 32'd0);
    idle(3);
    check("t1_count", 32'(wr_data.size() - base), 32'd2);
    check("t1_w0", log_d(base), 32'h20190040);
    check("t1_a0", log_a(base), 32'd0);
    check("t1_w1", log_d(base + 1), 32'h00008020);
    check("t1_a1", log_a(base + 1), 32'd1);

    // Bad checksum
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    base = wr_data.size();
    send(8'h02, 3);
    foreach (w2[i]) for (int k = 3; k >= 0; k--) send(w2[i][k*8 +: 8], 3);
    send(8'hD8, 2);
    check("t2_err", 32'(err), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_cpu_rst", 32'(cpu_rst), 32'd1);
    for (int i = 0; i < 6; i++) send(8'($urandom), 0);
    check("t2_count", 32'(wr_data.size() - base), 32'd2);

    // 21 words back-to-back
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    wfib = new[21];
    foreach (wfib[i]) wfib[i] = $urandom;
    wfib[0] = 32'h20190040; wfib[20] = 32'h1000FFFF;
    base = wr_data.size();
    send_frame(8'd21, wfib, 1'b1, 0);
    idle(2);
    check("t3_count", 32'(wr_data.size() - base), 32'd21);
    for (int i = 0; i < 21; i++) check("t3_word", log_d(base + i), wfib[i]);
    check("t3_last_addr", log_a(base + 20), 32'd20);
    check("t3_done", 32'(done), 32'd1);

    // N=0 means 128 words
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    wbig = new[128];
    foreach (wbig[i]) wbig[i] = 32'hA5A5A5A5;
    base = wr_data.size();
    send(8'h00, 0);
    for (int i = 0; i < 512; i++) send(8'hA5, 0);
    send(8'h00, 1);
    check("t4_count", 32'(wr_data.size() - base), 32'd128);
    check("t4_last_addr", log_a(base + 127), 32'd127);
    check("t4_done", 32'(done), 32'd1);

    // Reload mid-word
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    base = wr_data.size();
    send(8'h02, 0); send(8'h12, 1); send(8'h34, 0);
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    w1 = new[1];
    w1[0] = 32'hDEADBEEF;
    send(8'h01, 1);
    foreach (w1[i]) for (int k = 3; k >= 0; k--) send(w1[i][k*8 +: 8], 1);
    send(8'h22, 1);
    check("t5_count", 32'(wr_data.size() - base), 32'd1);
    check("t5_word", log_d(base), 32'hDEADBEEF);
    check("t5_addr", log_a(base), 32'd0);
    check("t5_done", 32'(done), 32'd1);

    // rst mid-load, then a good frame
    tick(1'b0, 8'd0, 1'b1, 1'b0);
    send(8'h02, 0);
    for (int i = 0; i < 5; i++) send(8'($urandom), 0);
    tick(1'b1, 8'h55, 1'b1, 1'b1);
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_addr", 32'(mem_addr), 32'd0);
    check("t6_rst_wdata", mem_wdata, 32'd0);
    base = wr_data.size();
    send_frame(8'h02, w2, 1'b1, 1);
    check("t6_count", 32'(wr_data.size() - base), 32'd2);
    check("t6_done", 32'(done), 32'd1);

    // Randomized frames with sporadic reload/rst injections
    for (int f = 0; f < 40; f++) begin
      int n;
      tick(1'b0, 8'd0, 1'b1, 1'b0);
      n = $urandom_range(1, 6);
      wr = new[n];
      foreach (wr[i]) wr[i] = $urandom;
      send(8'(n), $urandom_range(0, 2));
      foreach (wr[i]) begin
        for (int k = 3; k >= 0; k--) begin
          if ($urandom_range(0, 39) == 0)
            tick(1'($urandom), 8'($urandom), 1'b1, 1'($urandom_range(0, 3) == 0));
          send(wr[i][k*8 +: 8], $urandom_range(0, 2));
        end
      end
      send($urandom_range(0, 1) ? 8'($urandom) : 8'h00, $urandom_range(0, 2));
      for (int i = 0; i < 3; i++) send(8'($urandom), $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_prog_loader.md
Name: mips_prog_loader

Overview:
Upstream boot stage for the multicycle MIPS. It takes a byte stream from a serial receiver (UART RX, one byte per valid strobe, no backpressure) and packs it into 32-bit words. It writes those words into the unified instruction/data RAM starting at word address 0. While loading it holds the CPU in reset, and it releases the CPU only after a checksum-verified frame. This replaces the bench-only direct writes into the RAM array for FPGA bring-up.

Parameters:
ADDR_W, 7, word-address width of the unified RAM (128 words)
DATA_W, 32, RAM word width; fixed at 4 bytes

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
reload  in  1  one-cycle pulse; aborts any load and waits for a new frame
rx_valid  in  1  one-cycle strobe: rx_data holds a new byte
rx_data  in  8  received byte
mem_we  out  1  RAM write enable, one-cycle pulse per word
mem_addr  out  ADDR_W  RAM word address
mem_wdata  out  DATA_W  RAM write data
cpu_rst  out  1  reset to the MIPS core, active-high
busy  out  1  a frame is in progress
done  out  1  last frame loaded and verified
err  out  1  last frame failed its checksum

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - cpu_rst=1, busy=0, done=0, err=0, mem_we=0.
  - mem_addr=0, mem_wdata=0.
  - Internal state IDLE.
- Frame format: header byte N, then N words of 4 bytes each (big-endian, first byte = bits 31:24), then one checksum byte.
  - N=0 means 128 words.
  - Checksum = XOR of all data bytes; the header is excluded.
- FSM states: IDLE, DATA, CHECK, DONE, ERROR.
  - IDLE: on rx_valid, latch N, clear the byte counter (2 bits), word counter and XOR accumulator. Go to DATA and set busy=1, cpu_rst=1, done=0, err=0.
  - DATA: each rx_valid shifts the byte into the word register and XORs it into the accumulator.
    - On the 4th byte of a word, mem_we=1 in the next cycle, with mem_addr = word index and mem_wdata = assembled word.
    - Byte collection continues in the same cycle as the write; back-to-back rx_valid every cycle must be supported.
    - After word N-1 is written, go to CHECK. The write pulse and the transition happen in the same cycle.
  - CHECK: on rx_valid, compare the byte with the accumulator.
    - Match: go to DONE; busy=0, done=1, cpu_rst=0 in the cycle after the checksum byte.
    - Mismatch: go to ERROR; busy=0, err=1, cpu_rst stays 1.
  - DONE: rx_valid is ignored; cpu_rst stays 0 until reload or rst.
  - ERROR: rx_valid is ignored; only reload or rst leaves this state.
- Boundary conditions:
  - reload in any state, including mid-word or mid-write: go to IDLE next cycle with cpu_rst=1, busy=0, done=0, err=0, partial word discarded. A pending mem_we in the same cycle is suppressed.
  - reload and rx_valid in the same cycle: reload wins and the byte is dropped.
  - rst has priority over reload.
  - mem_addr never wraps: N≤128 and the word counter width is ADDR_W+1.
  - mem_we is never asserted outside DATA/CHECK, and never more than once per word.
  - cpu_rst must be 1 throughout any cycle in which mem_we=1.

Decomposition:
- Shared package mips_pkg:
  - loader_state_t enum (IDLE, DATA, CHECK, DONE, ERROR).
  - ADDR_W / DATA_W defaults.
  - BYTES_PER_WORD=4.
- One sub-module, loader_word_packer: shift register, 2-bit byte counter, word_ready pulse.
- The FSM, word counter and XOR accumulator stay in the top level.

Test Plan:
- Good 2-word frame: rst 3 cycles, then bytes 02, 20 19 00 40, 00 00 80 20, D9 (one byte every 4 cycles) → writes addr0=0x20190040 and addr1=0x00008020, exactly 2 mem_we pulses; done=1 and cpu_rst=0 one cycle after D9.
- Bad checksum: same frame with last byte 0xD8 → both words still written, err=1, cpu_rst stays 1, done=0; further bytes produce no mem_we.
- Back-to-back bytes: 21-word frame (the Fibonacci program words 0x20190040..0x1000FFFF) with rx_valid every cycle plus correct XOR → 21 writes to addresses 0..20 in order, no byte lost, done=1.
- N=0: 128 words of 0xA5A5A5A5 then checksum 0x00 → addresses 0..127 written, last addr=127, done=1.
- reload mid-word: send 02, 12 34, pulse reload, then a full good 1-word frame 01 DE AD BE EF 22 → only addr0=0xDEADBEEF is written, done=1.
- rst mid-load (after 6 bytes) → all outputs at reset values the next cycle; a following good frame loads normally.
